// File: rtl/ta_bank_pkg.sv
// ta_bank_pkg: feedback encodings, FSM state type and state-range helpers for the Tsetlin automaton bank.
package ta_bank_pkg;
  localparam logic [1:0] FB_NONE    = 2'b00;
  localparam logic [1:0] FB_REWARD  = 2'b01;
  localparam logic [1:0] FB_PENALTY = 2'b10;
  localparam logic [1:0] FB_RSVD    = 2'b11;
  typedef enum logic {IDLE, SWEEP} fsm_t;
  function automatic int ta_n(input int sb);
    return 1 << (sb - 1);
  endfunction
  function automatic int ta_max(input int sb);
    return (1 << sb) - 1;
  endfunction
endpackage

// File: rtl/ta_next_state.sv
// ta_next_state: combinational Tsetlin automaton transition for one state under reward/penalty.
module ta_next_state
  import ta_bank_pkg::*;
#(
  parameter int STATE_BITS = 4
) (
  input  logic [STATE_BITS-1:0] i_state,
  input  logic [1:0]            i_fb_type,
  output logic [STATE_BITS-1:0] o_state
);
  logic w_inc, w_dec;
  always_comb begin
    w_inc   = (i_fb_type == FB_REWARD && i_state[STATE_BITS-1]) || (i_fb_type == FB_PENALTY && !i_state[STATE_BITS-1]);
    w_dec   = (i_fb_type == FB_REWARD && !i_state[STATE_BITS-1]) || (i_fb_type == FB_PENALTY && i_state[STATE_BITS-1]);
    o_state = (w_inc && i_state != STATE_BITS'(ta_max(STATE_BITS))) ? i_state + 1'b1 :
              (w_dec && i_state != '0) ? i_state - 1'b1 : i_state;
  end
endmodule

// File: rtl/ta_bank.sv
// ta_bank: bank of Tsetlin automata with single-TA and broadcast-sweep feedback and a saturating flip counter.
// Optional macro TA_BANK_LOAD_EN adds a direct state-load port that overrides feedback to the same TA.
module ta_bank
  import ta_bank_pkg::*;
#(
  parameter int NUM_TA     = 8,
  parameter int STATE_BITS = 4,
  parameter int INIT_STATE = ta_n(STATE_BITS) - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fb_valid,
  output logic                      fb_ready,
  input  logic                      fb_all,
  input  logic [$clog2(NUM_TA)-1:0] fb_idx,
  input  logic [1:0]                fb_type,
`ifdef TA_BANK_LOAD_EN
  input  logic                      ld_en,
  input  logic [$clog2(NUM_TA)-1:0] ld_idx,
  input  logic [STATE_BITS-1:0]     ld_state,
`else
`endif
  output logic [NUM_TA-1:0]         action,
  output logic [15:0]               flip_cnt,
  output logic                      sweep_done
);
  localparam int IW = $clog2(NUM_TA);
  logic [STATE_BITS-1:0] r_state [NUM_TA];
  logic [STATE_BITS-1:0] w_nx [NUM_TA];
  fsm_t                  r_fsm, w_fsm_nxt;
  logic [IW-1:0]         r_idx, w_sel_idx;
  logic [1:0]            r_type, w_sel_type;
  logic [STATE_BITS-1:0] w_cur, w_upd;
  logic                  w_wr, w_last, r_done;
  logic [NUM_TA-1:0]     w_nx_act;
  logic [16:0]           w_flips, w_sum;
  logic [15:0]           r_flip;
  // One transition unit serves both the single-update and the sweep path.
  ta_next_state #(.STATE_BITS(STATE_BITS)) u_next (
    .i_state  (w_cur),
    .i_fb_type(w_sel_type),
    .o_state  (w_upd)
  );
  always_comb begin
    w_last     = r_fsm == SWEEP && 32'(r_idx) == NUM_TA - 1;
    w_fsm_nxt  = r_fsm == IDLE ? ((fb_valid && fb_all) ? SWEEP : IDLE) : (w_last ? IDLE : SWEEP);
    w_sel_idx  = r_fsm == SWEEP ? r_idx : fb_idx;
    w_sel_type = r_fsm == SWEEP ? r_type : fb_type;
    w_cur      = 32'(w_sel_idx) < NUM_TA ? r_state[w_sel_idx] : '0;
    w_wr       = r_fsm == SWEEP || (fb_valid && !fb_all && 32'(fb_idx) < NUM_TA);
  end
  always_comb begin
    w_flips = '0;
    for (int i = 0; i < NUM_TA; i++) begin
      action[i] = r_state[i][STATE_BITS-1];
      w_nx[i]   = (w_wr && 32'(w_sel_idx) == i) ? w_upd : r_state[i];
`ifdef TA_BANK_LOAD_EN
      if (ld_en && 32'(ld_idx) == i) w_nx[i] = ld_state;
`endif
      w_nx_act[i] = w_nx[i][STATE_BITS-1];
      w_flips     = w_flips + 17'(w_nx_act[i] ^ action[i]);
    end
    w_sum = {1'b0, r_flip} + w_flips;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_fsm <= IDLE;
    else r_fsm <= w_fsm_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx  <= '0;
      r_type <= FB_NONE;
      r_done <= 1'b0;
      r_flip <= '0;
      for (int i = 0; i < NUM_TA; i++) r_state[i] <= STATE_BITS'(INIT_STATE);
    end else begin
      r_idx  <= r_fsm == IDLE ? '0 : r_idx + 1'b1;
      r_type <= (r_fsm == IDLE && fb_valid && fb_all) ? fb_type : r_type;
      r_done <= w_last;
      r_flip <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      for (int i = 0; i < NUM_TA; i++) r_state[i] <= w_nx[i];
    end
  assign fb_ready   = r_fsm == IDLE;
  assign flip_cnt   = r_flip;
  assign sweep_done = r_done;
endmodule

// File: tb/tb_ta_bank.sv
// tb_ta_bank: directed stimulus with a queued-expectation scoreboard for ta_bank (default parameters).
module tb_ta_bank;
  import ta_bank_pkg::*;
  logic        clk = 0, rst = 1, fb_valid = 0, fb_all = 0;
  logic [2:0]  fb_idx = '0;
  logic [1:0]  fb_type = '0;
  logic        fb_ready, sweep_done;
  logic [7:0]  action;
  logic [15:0] flip_cnt;
  int          checks = 0, errors = 0;
  logic [7:0]  q_act[$];
  logic [15:0] q_flip[$];
  logic        hs_single = 0;

  ta_bank dut (
    .clk(clk), .rst(rst), .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_all(fb_all),
    .fb_idx(fb_idx), .fb_type(fb_type), .action(action), .flip_cnt(flip_cnt), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  always @(posedge clk or posedge rst) hs_single <= rst ? 1'b0 : (fb_valid && fb_ready && !fb_all);

  always @(negedge clk)
    if (hs_single || sweep_done) begin
      if (q_act.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: action %0h flip_cnt %0h with nothing expected", action, flip_cnt);
      end else begin
        chk("action", action, q_act.pop_front());
        chk("flip_cnt", flip_cnt, q_flip.pop_front());
      end
    end

  task automatic send(input logic all, input logic [2:0] idx, input logic [1:0] ty,
                      input logic [7:0] ea, input logic [15:0] ef);
    int n = 0;
    while (!fb_ready && n < 50) begin n++; @(negedge clk); end
    chk("ready_before_send", fb_ready, 1);
    q_act.push_back(ea);
    q_flip.push_back(ef);
    fb_valid = 1; fb_all = all; fb_idx = idx; fb_type = ty;
    @(negedge clk);
    fb_valid = 0; fb_all = 0;
    if (all) begin
      n = 0;
      while (!fb_ready && n < 20) begin n++; @(negedge clk); end
      chk("ready_low_cycles", n, 8);
      chk("sweep_done_pulse", sweep_done, 1);
      @(negedge clk);
      chk("sweep_done_clear", sweep_done, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_action", action, 8'h00);
    chk("reset_flip_cnt", flip_cnt, 0);
    chk("reset_fb_ready", fb_ready, 1);
    chk("reset_sweep_done", sweep_done, 0);
    // idx 3: 7 -> 8 flips to include, then saturate at 15 and walk back across
    send(0, 3, FB_PENALTY, 8'h08, 1);
    repeat (10) send(0, 3, FB_REWARD, 8'h08, 1);
    repeat (7) send(0, 3, FB_PENALTY, 8'h08, 1);
    send(0, 3, FB_PENALTY, 8'h00, 2);
    // idx 0: rewards saturate at 0, so exactly 8 penalties are needed to flip
    do_reset();
    repeat (9) send(0, 0, FB_REWARD, 8'h00, 0);
    repeat (7) send(0, 0, FB_PENALTY, 8'h00, 0);
    send(0, 0, FB_PENALTY, 8'h01, 1);
    // broadcast penalty flips all eight
    do_reset();
    send(1, 0, FB_PENALTY, 8'hFF, 8);
    send(0, 2, FB_RSVD, 8'hFF, 8);
    send(0, 4, FB_NONE, 8'hFF, 8);
    send(1, 0, FB_RSVD, 8'hFF, 8);
    // all states 9 after broadcast reward; idx 5 needs two penalties to flip
    send(1, 0, FB_REWARD, 8'hFF, 8);
    send(0, 5, FB_PENALTY, 8'hFF, 8);
    send(0, 5, FB_PENALTY, 8'hDF, 9);
    // abandon a broadcast with an asynchronous reset mid-sweep
    fb_valid = 1; fb_all = 1; fb_type = FB_PENALTY;
    @(negedge clk);
    fb_valid = 0; fb_all = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_action", action, 8'h00);
    chk("abort_flip_cnt", flip_cnt, 0);
    chk("abort_fb_ready", fb_ready, 1);
    chk("abort_sweep_done", sweep_done, 0);
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    send(0, 1, FB_PENALTY, 8'h02, 1);
    @(negedge clk);
    chk("queue_drained", q_act.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
